// File: rtl/pio_edge_irq_db.sv
// rtl/pio_edge_irq_db.sv - Avalon-MM input PIO with per-bit debounce, edge-mode capture, IRQ and event counter
module pio_edge_irq_db #(
  parameter int WIDTH            = 4,
  parameter int SYNC_STAGES      = 2,
  parameter int CNT_W            = 16,
  parameter int DEBOUNCE_DEFAULT = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam logic [2:0] A_DATA   = 3'd0;
  localparam logic [2:0] A_MODE   = 3'd1;
  localparam logic [2:0] A_MASK   = 3'd2;
  localparam logic [2:0] A_CAP    = 3'd3;
  localparam logic [2:0] A_THRESH = 3'd4;
  localparam logic [2:0] A_RAW    = 3'd5;
  localparam logic [2:0] A_EVENTS = 3'd6;

  logic                 wr_en;
  logic [WIDTH-1:0]     sync_q [SYNC_STAGES];
  logic [WIDTH-1:0]     s;
  logic [WIDTH-1:0]     deb;
  logic [WIDTH-1:0]     deb_d;
  logic [CNT_W-1:0]     cnt [WIDTH];
  logic [CNT_W:0]       cnt_inc [WIDTH];
  logic [CNT_W-1:0]     thresh;
  logic [CNT_W-1:0]     t_eff;
  logic [2*WIDTH-1:0]   mode;
  logic [WIDTH-1:0]     irq_mask;
  logic [WIDTH-1:0]     edge_capture;
  logic [15:0]          events;
  logic [WIDTH-1:0]     rise;
  logic [WIDTH-1:0]     fall;
  logic [WIDTH-1:0]     ev;
  logic [31:0]          rd_mux;
  logic                 unused_wdata;

  assign wr_en        = chipselect & ~write_n;
  assign unused_wdata = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // THRESH of 0 behaves like 1; the extra counter bit keeps cnt+1 from wrapping.
  assign t_eff = (thresh == '0) ? CNT_W'(1) : thresh;

  always_comb begin
    for (int i = 0; i < WIDTH; i++) cnt_inc[i] = {1'b0, cnt[i]} + (CNT_W+1)'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb   <= '0;
      deb_d <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      deb_d <= deb;
      for (int i = 0; i < WIDTH; i++) begin
        if (s[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt_inc[i] >= {1'b0, t_eff}) begin
          deb[i] <= s[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt_inc[i][CNT_W-1:0];
        end
      end
    end
  end

  assign rise = deb & ~deb_d;
  assign fall = ~deb & deb_d;

  always_comb begin
    ev = '0;
    for (int i = 0; i < WIDTH; i++) begin
      case (mode[2*i +: 2])
        2'b00:   ev[i] = rise[i];
        2'b01:   ev[i] = fall[i];
        2'b10:   ev[i] = rise[i] | fall[i];
        default: ev[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode     <= '0;
      irq_mask <= '0;
      thresh   <= CNT_W'(DEBOUNCE_DEFAULT);
    end else if (wr_en) begin
      case (address)
        A_MODE:   mode     <= writedata[2*WIDTH-1:0];
        A_MASK:   irq_mask <= writedata[WIDTH-1:0];
        A_THRESH: thresh   <= writedata[CNT_W-1:0];
        default:  ;
      endcase
    end
  end

  // A new event outranks a same-cycle clear so no edge is lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_capture <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (ev[i]) begin
          edge_capture[i] <= 1'b1;
        end else if (wr_en && address == A_CAP && writedata[i]) begin
          edge_capture[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      events <= '0;
    end else if (wr_en && address == A_EVENTS) begin
      events <= {15'd0, |ev};
    end else if (|ev && events != 16'hFFFF) begin
      events <= events + 16'd1;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      A_DATA:   rd_mux[WIDTH-1:0]   = deb;
      A_MODE:   rd_mux[2*WIDTH-1:0] = mode;
      A_MASK:   rd_mux[WIDTH-1:0]   = irq_mask;
      A_CAP:    rd_mux[WIDTH-1:0]   = edge_capture;
      A_THRESH: rd_mux[CNT_W-1:0]   = thresh;
      A_RAW:    rd_mux[WIDTH-1:0]   = s;
      A_EVENTS: rd_mux[15:0]        = events;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_mux;
  end

  assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_pio_edge_irq_db.sv
// tb/tb_pio_edge_irq_db.sv - self-checking bench for pio_edge_irq_db
module tb_pio_edge_irq_db;
  localparam int WIDTH            = 4;
  localparam int SYNC_STAGES      = 2;
  localparam int CNT_W            = 16;
  localparam int DEBOUNCE_DEFAULT = 50000;

  logic             clk = 1'b0;
  logic             reset_n = 1'b1;
  logic [2:0]       address = '0;
  logic             chipselect = 1'b0;
  logic             write_n = 1'b1;
  logic [31:0]      writedata = '0;
  logic [31:0]      readdata;
  logic [WIDTH-1:0] in_port = '0;
  logic             irq;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pio_edge_irq_db #(
    .WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES), .CNT_W(CNT_W), .DEBOUNCE_DEFAULT(DEBOUNCE_DEFAULT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .irq(irq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic read_reg(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a;
    @(posedge clk);
    #1 d = readdata;
  endtask

  task automatic write_reg(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk);
    #1 chipselect = 1'b0; write_n = 1'b0 | 1'b1;
  endtask

  // Reference: a delay line for the synchroniser and a run-length rule for debounce.
  logic [WIDTH-1:0]   m_pipe [$];
  logic [WIDTH-1:0]   m_deb, m_deb_prev, m_cap, m_mask, m_s, m_ev;
  logic [2*WIDTH-1:0] m_mode;
  logic [CNT_W-1:0]   m_thresh;
  int                 m_run [WIDTH];
  int                 m_events;
  int                 m_t;
  logic               m_w;
  logic [31:0]        m_rd;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_pipe.delete();
      for (int k = 0; k < SYNC_STAGES; k++) m_pipe.push_back('0);
      m_deb = '0; m_deb_prev = '0; m_cap = '0; m_mask = '0; m_mode = '0;
      m_thresh = CNT_W'(DEBOUNCE_DEFAULT);
      for (int i = 0; i < WIDTH; i++) m_run[i] = 0;
      m_events = 0;
      m_rd = '0;
    end else begin
      m_s = m_pipe[0];
      case (address)
        3'd0:    m_rd = 32'(m_deb);
        3'd1:    m_rd = 32'(m_mode);
        3'd2:    m_rd = 32'(m_mask);
        3'd3:    m_rd = 32'(m_cap);
        3'd4:    m_rd = 32'(m_thresh);
        3'd5:    m_rd = 32'(m_s);
        3'd6:    m_rd = 32'(m_events);
        default: m_rd = '0;
      endcase
      m_w  = chipselect && !write_n;
      m_ev = '0;
      for (int i = 0; i < WIDTH; i++) begin
        case (m_mode[2*i +: 2])
          2'b00:   m_ev[i] = m_deb[i] && !m_deb_prev[i];
          2'b01:   m_ev[i] = !m_deb[i] && m_deb_prev[i];
          2'b10:   m_ev[i] = m_deb[i] != m_deb_prev[i];
          default: m_ev[i] = 1'b0;
        endcase
        if (m_ev[i]) m_cap[i] = 1'b1;
        else if (m_w && address == 3'd3 && writedata[i]) m_cap[i] = 1'b0;
      end
      if (m_w && address == 3'd6) m_events = (m_ev != 0) ? 1 : 0;
      else if (m_ev != 0) m_events = (m_events < 65535) ? m_events + 1 : 65535;
      m_deb_prev = m_deb;
      m_t = (m_thresh == 0) ? 1 : int'(m_thresh);
      for (int i = 0; i < WIDTH; i++) begin
        if (m_s[i] != m_deb[i]) begin
          m_run[i]++;
          if (m_run[i] >= m_t) begin
            m_deb[i] = m_s[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      if (m_w && address == 3'd1) m_mode = writedata[2*WIDTH-1:0];
      if (m_w && address == 3'd2) m_mask = writedata[WIDTH-1:0];
      if (m_w && address == 3'd4) m_thresh = writedata[CNT_W-1:0];
      m_pipe.push_back(in_port);
      void'(m_pipe.pop_front());
    end
  end

  typedef struct {
    logic        wr;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs [$];
  logic [31:0] rd;
  int          r;
  int          waited;

  initial begin
    for (int a = 0; a < 8; a++)
      vecs.push_back('{1'b0, 3'(a), 32'h0, (a == 4) ? 32'(DEBOUNCE_DEFAULT) : 32'h0});
    vecs.push_back('{1'b1, 3'd1, 32'hFFFF_FFFF, 32'h0000_00FF});
    vecs.push_back('{1'b1, 3'd1, 32'h0000_0024, 32'h0000_0024});
    vecs.push_back('{1'b1, 3'd2, 32'hFFFF_FFF5, 32'h0000_0005});
    vecs.push_back('{1'b1, 3'd4, 32'h0001_2345, 32'h0000_2345});
    vecs.push_back('{1'b1, 3'd4, 32'h0000_0000, 32'h0000_0000});
    vecs.push_back('{1'b1, 3'd0, 32'hFFFF_FFFF, 32'h0000_0000});
    vecs.push_back('{1'b1, 3'd5, 32'h0000_000F, 32'h0000_0000});
    vecs.push_back('{1'b1, 3'd7, 32'hFFFF_FFFF, 32'h0000_0000});
    vecs.push_back('{1'b1, 3'd3, 32'h0000_000F, 32'h0000_0000});
    vecs.push_back('{1'b1, 3'd6, 32'h0000_1234, 32'h0000_0000});
    vecs.push_back('{1'b1, 3'd1, 32'h0000_0000, 32'h0000_0000});
    vecs.push_back('{1'b1, 3'd2, 32'h0000_0000, 32'h0000_0000});

    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("irq_in_reset", {31'd0, irq}, 32'd0);
    check("rd_in_reset", readdata, 32'd0);
    @(negedge clk) reset_n = 1'b1;

    for (int k = 0; k < vecs.size(); k++) begin
      if (vecs[k].wr) write_reg(vecs[k].addr, vecs[k].wdata);
      read_reg(vecs[k].addr, rd);
      check($sformatf("vec%0d_addr%0d", k, vecs[k].addr), rd, vecs[k].exp);
    end
    check("irq_after_table", {31'd0, irq}, 32'd0);

    // Input to irq latency: SYNC_STAGES + T + 1 edges with T=4.
    write_reg(3'd4, 32'd4);
    write_reg(3'd2, 32'd1);
    @(negedge clk);
    address = 3'd0;
    in_port[0] = 1'b1;
    for (int k = 1; k <= SYNC_STAGES + 5; k++) begin
      @(posedge clk);
      #1;
      if (k >= SYNC_STAGES + 4) begin
        check($sformatf("lat_irq_e%0d", k), {31'd0, irq}, (k == SYNC_STAGES + 5) ? 32'd1 : 32'd0);
        check($sformatf("lat_data_e%0d", k), {31'd0, readdata[0]}, (k == SYNC_STAGES + 5) ? 32'd1 : 32'd0);
      end
    end
    read_reg(3'd6, rd);
    check("lat_events", rd, 32'd1);
    write_reg(3'd3, 32'd1);
    check("lat_irq_cleared", {31'd0, irq}, 32'd0);

    // Glitch of 3 cycles with T=4 is filtered.
    @(negedge clk) in_port[1] = 1'b1;
    repeat (3) @(negedge clk);
    in_port[1] = 1'b0;
    repeat (10) @(posedge clk);
    read_reg(3'd0, rd);
    check("glitch_data", rd, 32'h1);
    read_reg(3'd3, rd);
    check("glitch_cap", rd, 32'h0);
    read_reg(3'd6, rd);
    check("glitch_events", rd, 32'h1);

    // Falling-only mode on bit 2.
    write_reg(3'd1, 32'h10);
    write_reg(3'd2, 32'h4);
    @(negedge clk) in_port[2] = 1'b1;
    repeat (12) @(posedge clk);
    read_reg(3'd3, rd);
    check("fall_rise_nocap", rd, 32'h0);
    check("fall_rise_noirq", {31'd0, irq}, 32'd0);
    read_reg(3'd0, rd);
    check("fall_data_high", rd, 32'h5);
    @(negedge clk) in_port[2] = 1'b0;
    repeat (12) @(posedge clk);
    read_reg(3'd3, rd);
    check("fall_cap", rd, 32'h4);
    check("fall_irq", {31'd0, irq}, 32'd1);
    write_reg(3'd3, 32'h4);
    check("fall_irq_drop", {31'd0, irq}, 32'd0);
    read_reg(3'd3, rd);
    check("fall_cap_clear", rd, 32'h0);

    // W1C on the same edge as a new event on bit 0 (T=1, any-edge).
    write_reg(3'd4, 32'd1);
    write_reg(3'd1, 32'h2);
    repeat (4) @(posedge clk);
    @(negedge clk) in_port[0] = 1'b0;
    repeat (3) @(posedge clk);
    write_reg(3'd3, 32'h1);
    read_reg(3'd3, rd);
    check("w1c_vs_set", rd, 32'h1);
    write_reg(3'd3, 32'h1);
    read_reg(3'd3, rd);
    check("w1c_idle", rd, 32'h0);

    // Asynchronous reset in the middle of a count, with bit 3 held high through it.
    write_reg(3'd4, 32'd10);
    @(negedge clk);
    address = 3'd4;
    in_port[3] = 1'b1;
    repeat (6) @(posedge clk);
    #3 reset_n = 1'b0;
    #1 check("async_rst_rd", readdata, 32'd0);
    check("async_rst_irq", {31'd0, irq}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    write_reg(3'd4, 32'd2);
    write_reg(3'd2, 32'h8);
    waited = 0;
    while (irq !== 1'b1 && waited < 30) begin
      @(posedge clk);
      #1 waited++;
    end
    check("held_high_rise_irq", {31'd0, irq}, 32'd1);
    read_reg(3'd3, rd);
    check("held_high_cap", rd, 32'h8);

    // Randomised traffic against the reference model.
    write_reg(3'd4, 32'd3);
    write_reg(3'd1, $urandom);
    write_reg(3'd2, $urandom);
    write_reg(3'd3, 32'hF);
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      check($sformatf("rand_rd[%0d]", n), readdata, m_rd);
      check($sformatf("rand_irq[%0d]", n), {31'd0, irq}, {31'd0, |(m_cap & m_mask)});
      chipselect = 1'b0;
      write_n = 1'b1;
      for (int b = 0; b < WIDTH; b++)
        if ($urandom_range(0, 5) == 0) in_port[b] = ~in_port[b];
      address = 3'($urandom_range(0, 7));
      r = $urandom_range(0, 31);
      if (r <= 5) begin
        chipselect = 1'b1;
        write_n = 1'b0;
        writedata = $urandom;
        case (r)
          0, 1: address = 3'd3;
          2: address = 3'd6;
          3: address = 3'd1;
          4: begin address = 3'd4; writedata = 32'($urandom_range(0, 4)); end
          default: address = 3'd2;
        endcase
      end
    end
    @(negedge clk);
    chipselect = 1'b0;
    write_n = 1'b1;

    // Saturation of EVENTS, then a clear that coincides with an event.
    write_reg(3'd4, 32'd1);
    write_reg(3'd1, 32'hAA);
    repeat (10) @(posedge clk);
    write_reg(3'd6, 32'd0);
    for (int n = 0; n < 70000; n++) begin
      @(negedge clk) in_port[3] = ~in_port[3];
    end
    repeat (6) @(posedge clk);
    read_reg(3'd6, rd);
    check("events_saturated", rd, 32'hFFFF);
    @(negedge clk) in_port[0] = ~in_port[0];
    repeat (3) @(posedge clk);
    write_reg(3'd6, 32'd0);
    read_reg(3'd6, rd);
    check("events_clear_with_event", rd, 32'd1);
    write_reg(3'd6, 32'd0);
    read_reg(3'd6, rd);
    check("events_clear_idle", rd, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pio_edge_irq_db.md
# pio_edge_irq_db

Parametrised Avalon-MM input PIO for push-buttons and switches on the Nios II system bus. It is the next-generation key-input peripheral. It adds the following over the fixed 2-bit edge-capture PIO:
- configurable port width and synchroniser depth;
- a per-bit programmable debounce filter;
- per-bit edge-mode selection (rising, falling, any, off);
- a saturating event counter.

It raises a level-sensitive IRQ to the Nios II interrupt controller.

## Interface
Parameters:
- WIDTH, 4, number of input bits; legal range 1..16.
- SYNC_STAGES, 2, metastability flip-flops per bit; legal range 2..4.
- CNT_W, 16, debounce counter and threshold width; legal range 1..32.
- DEBOUNCE_DEFAULT, 50000, reset value of the threshold register.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous, active-low.
- address  in  3  word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- in_port  in  WIDTH  asynchronous external inputs.
- irq  out  1  interrupt request, active-high.

## Operation
- A write occurs when chipselect=1 and write_n=0. Writes to read-only addresses are ignored.
- readdata is updated every clock cycle from the address mux, independent of chipselect. Unused and unmapped bits read 0.

Register map:
- 0 DATA (RO): debounced levels deb[WIDTH-1:0].
- 1 MODE (RW): 2 bits per input, mode[2i+1:2i]. 00 = rising, 01 = falling, 10 = any edge, 11 = disabled. Reset value 0.
- 2 IRQ_MASK (RW): WIDTH bits. Reset value 0.
- 3 EDGE_CAPTURE (R/W1C): WIDTH bits. Writing 1 to a bit clears it. Reset value 0.
- 4 THRESH (RW): CNT_W bits. Reset value DEBOUNCE_DEFAULT.
- 5 RAW (RO): synchroniser outputs s[WIDTH-1:0].
- 6 EVENTS (RW): 16-bit saturating counter. Any write clears it. Reset value 0.

Synchroniser:
- Each bit passes through a chain of SYNC_STAGES flops, all reset to 0. The chain output is s[i].

Debounce, per bit, with counter cnt[i] of CNT_W bits, reset 0; deb resets to 0:
- If s[i]==deb[i]: cnt[i] <= 0.
- Else, with effective threshold T = max(THRESH,1):
  - if cnt[i]+1 >= T: deb[i] <= s[i] and cnt[i] <= 0;
  - otherwise cnt[i] <= cnt[i]+1.
- THRESH of 0 or 1 gives a one-cycle filter.
- A THRESH write takes effect on the next cycle. If a count is in progress and cnt+1 is already at or above the new T, deb flips on the next cycle.
- A glitch shorter than T cycles never changes deb; any return to the deb level restarts the count.

Edge detect:
- deb_d is deb delayed by one cycle, reset 0.
- rise[i] = deb[i] & ~deb_d[i]; fall[i] = ~deb[i] & deb_d[i].
- ev[i] is selected by mode: rise, fall, rise|fall, or 0.

Edge capture and IRQ:
- If ev[i]=1, edge_capture[i] <= 1.
- Else if a write to address 3 has writedata[i]=1, edge_capture[i] <= 0.
- A set in the same cycle as a clear wins, so no event is lost.
- irq = |(edge_capture & irq_mask), combinational from the registers.

Event counter:
- Increments by 1 in each cycle where |ev=1, regardless of edge_capture state, and saturates at 0xFFFF.
- A write to address 6 in the same cycle as an event leaves the counter at 1.

## Timing
- All outputs after reset: readdata=0, irq=0.
- An input held high through reset produces a rising event once it propagates.
- Read latency is 1 cycle: readdata is valid on the edge after the address is presented.
- Input change to irq, with the input stable and T≥1: s changes SYNC_STAGES edges after in_port; deb flips T edges later; edge_capture sets 1 edge later; irq follows combinationally. Total: SYNC_STAGES+T+1 edges.
- Write to a register: the new value is visible in that register the next cycle, and on readdata one cycle after that.
- IRQ_MASK write to 1 while the capture bit is already set: irq asserts the cycle after the write edge.
- Simultaneous events on several bits in one cycle increment EVENTS by exactly 1.
- Asynchronous reset mid-count clears all counters, synchronisers, deb and capture bits immediately.

## Test plan
- Reset, then read all addresses -> THRESH reads DEBOUNCE_DEFAULT; all others read 0; irq=0.
- THRESH=4, MODE=0, mask=1, in_port[0] 0→1 and held -> DATA[0]=1 and irq=1 exactly SYNC_STAGES+5 edges after the change; EVENTS=1.
- THRESH=4, 3-cycle pulse on bit 1 -> DATA, EDGE_CAPTURE and EVENTS are unchanged.
- MODE bit2 = 01 (falling), bit 2 goes 1→0 -> rise produces no capture; fall sets capture[2]. Write 0x4 to address 3 -> capture[2]=0 and irq drops next cycle.
- W1C to bit 0 in the same cycle as a new ev[0] -> capture[0] stays 1.
- Drive 70000 toggles with THRESH=1 -> EVENTS saturates at 0xFFFF. A write to address 6 coinciding with an event -> EVENTS=1.
